// File: rtl/dwpw_window_router_pkg.sv
// Shared types and helpers for the depthwise/pointwise window router.
package dr_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    EMIT,
    DONE
  } state_e;

  typedef enum logic {
    MODE_DW = 1'b0,
    MODE_PW = 1'b1
  } mode_e;

  // Index width that never collapses to zero bits for tiny parameters.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Kernel size is forced into 1..kmax.
  function automatic int clamp_ksize(input int k, input int kmax);
    if (k < 1) return 1;
    if (k > kmax) return kmax;
    return k;
  endfunction

  // Pointwise beat count cannot exceed the line width.
  function automatic int clamp_pwcols(input int c, input int bufw);
    return (c > bufw) ? bufw : c;
  endfunction

endpackage

// File: rtl/dwpw_window_router_if.sv
// Beat channel from the router to the compute arrays.
interface dwpw_window_router_if #(
  parameter int DW   = 32,
  parameter int POY  = 3,
  parameter int POX  = 16,
  parameter int KMAX = 3,
  parameter int BUFW = 34
);
  import dr_pkg::*;

  localparam int KW = idx_w(KMAX);
  localparam int CW = idx_w(BUFW);

  logic                            out_valid;
  logic                            out_ready;
  logic                            blkend;
  logic [POY-1:0][POX-1:0][DW-1:0] dwpixel_array;
  logic [POY-1:0][DW-1:0]          pwpixel_array;
  logic [KW-1:0]                   tap_ky;
  logic [KW-1:0]                   tap_kx;
  logic [CW-1:0]                   pw_col;

  modport master (
    output out_valid, blkend, dwpixel_array, pwpixel_array, tap_ky, tap_kx, pw_col,
    input  out_ready
  );

  modport slave (
    input  out_valid, blkend, dwpixel_array, pwpixel_array, tap_ky, tap_kx, pw_col,
    output out_ready
  );

endinterface

// File: rtl/dwpw_window_router_tap_mux.sv
// Selects line[y][x*S+kx] for every output position of a depthwise beat.
module dr_tap_mux
  import dr_pkg::*;
#(
  parameter int DW   = 32,
  parameter int POY  = 3,
  parameter int POX  = 16,
  parameter int BUFW = 34,
  parameter int SMAX = 2
) (
  input  logic [POY-1:0][BUFW-1:0][DW-1:0] line,
  input  logic                             stride,
  input  logic [idx_w(BUFW)-1:0]           kx,
  output logic [POY-1:0][POX-1:0][DW-1:0]  sel
);

  localparam int CW = idx_w(BUFW);

  int step;

  // Strided column pick; the top guarantees the index stays inside the line.
  always_comb begin
    step = (stride && SMAX >= 2) ? 2 : 1;
    sel  = '0;
    for (int y = 0; y < POY; y++) begin
      for (int x = 0; x < POX; x++) begin
        sel[y][x] = line[y][CW'(x * step + int'(kx))];
      end
    end
  end

endmodule

// File: rtl/dwpw_window_router.sv
// Fetches strided kernel rows from the line buffer and emits DW or PW beats.
module dwpw_window_router
  import dr_pkg::*;
#(
  parameter int DW   = 32,
  parameter int POY  = 3,
  parameter int POX  = 16,
  parameter int KMAX = 3,
  parameter int SMAX = 2,
  parameter int BUFW = 34
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic                             mode,
  input  logic [idx_w(KMAX+1)-1:0]         ksize,
  input  logic                             stride,
  input  logic [idx_w(BUFW+1)-1:0]         pw_cols,
  output logic                             busy,
  output logic                             done,
  output logic                             rd_en,
  output logic [idx_w(KMAX)-1:0]           rd_row,
  input  logic [POY-1:0][BUFW-1:0][DW-1:0] rd_data,
  dwpw_window_router_if.master             bus
);

  localparam int KW = idx_w(KMAX);
  localparam int CW = idx_w(BUFW);

  if ((POX - 1) * SMAX + KMAX > BUFW) begin : g_cfg_check
    $error("dwpw_window_router: (POX-1)*SMAX+KMAX exceeds BUFW");
  end

  state_e                          state_q, state_n;
  mode_e                           mode_q;
  logic                            stride_q;
  logic [KW-1:0]                   klast_q;
  logic [CW-1:0]                   pwlast_q;
  logic [KW-1:0]                   kx_q, kx_n, ky_q, ky_n;
  logic [CW-1:0]                   col_q, col_n;
  logic [POY-1:0][BUFW-1:0][DW-1:0] line_q, line_n;
  logic [POY-1:0][POX-1:0][DW-1:0] dw_sel;
  logic [POY-1:0][DW-1:0]          pw_sel;
  logic                            last_beat;
  logic                            load_out;
  int                              pw_clamped;

  // Next state, next counters and the line register source for this cycle.
  always_comb begin
    state_n    = state_q;
    kx_n       = kx_q;
    ky_n       = ky_q;
    col_n      = col_q;
    line_n     = line_q;
    pw_clamped = clamp_pwcols(int'(pw_cols), BUFW);
    last_beat  = (mode_q == MODE_DW) ? (kx_q == klast_q && ky_q == klast_q)
                                     : (col_q == pwlast_q);
    case (state_q)
      IDLE: begin
        if (start) begin
          kx_n    = '0;
          ky_n    = '0;
          col_n   = '0;
          state_n = (mode == 1'b1 && pw_cols == '0) ? DONE : FETCH;
        end
      end
      FETCH: state_n = LOAD;
      LOAD: begin
        line_n  = rd_data;
        state_n = EMIT;
      end
      EMIT: begin
        if (bus.out_ready) begin
          if (mode_q == MODE_DW) begin
            if (kx_q != klast_q) begin
              kx_n = kx_q + KW'(1);
            end else if (ky_q != klast_q) begin
              kx_n    = '0;
              ky_n    = ky_q + KW'(1);
              state_n = FETCH;
            end else begin
              state_n = DONE;
            end
          end else begin
            if (col_q == pwlast_q) begin
              state_n = DONE;
            end else begin
              col_n = col_q + CW'(1);
            end
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    load_out = (state_n == EMIT) && ((state_q == LOAD) || (state_q == EMIT && bus.out_ready));
  end

  dr_tap_mux #(
    .DW   (DW),
    .POY  (POY),
    .POX  (POX),
    .BUFW (BUFW),
    .SMAX (SMAX)
  ) u_tap_mux (
    .line   (line_n),
    .stride (stride_q),
    .kx     (CW'(kx_n)),
    .sel    (dw_sel)
  );

  // Pointwise beat picks one column of every row.
  always_comb begin
    pw_sel = '0;
    for (int y = 0; y < POY; y++) begin
      pw_sel[y] = line_n[y][col_n];
    end
  end

  // Control state, counters, line register and configuration latched at start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mode_q   <= MODE_DW;
      stride_q <= 1'b0;
      klast_q  <= '0;
      pwlast_q <= '0;
      kx_q     <= '0;
      ky_q     <= '0;
      col_q    <= '0;
      line_q   <= '0;
    end else begin
      state_q <= state_n;
      kx_q    <= kx_n;
      ky_q    <= ky_n;
      col_q   <= col_n;
      line_q  <= line_n;
      if (state_q == IDLE && start) begin
        mode_q   <= mode_e'(mode);
        stride_q <= stride;
        klast_q  <= KW'(clamp_ksize(int'(ksize), KMAX) - 1);
        pwlast_q <= (pw_clamped == 0) ? '0 : CW'(pw_clamped - 1);
      end
    end
  end

  // Beat registers load only when a new beat is presented, so stalls hold them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.dwpixel_array <= '0;
      bus.pwpixel_array <= '0;
      bus.tap_ky        <= '0;
      bus.tap_kx        <= '0;
      bus.pw_col        <= '0;
    end else if (load_out) begin
      if (mode_q == MODE_DW) begin
        bus.dwpixel_array <= dw_sel;
        bus.tap_ky        <= ky_n;
        bus.tap_kx        <= kx_n;
      end else begin
        bus.pwpixel_array <= pw_sel;
        bus.pw_col        <= col_n;
      end
    end
  end

  assign bus.out_valid = (state_q == EMIT);
  assign bus.blkend    = (state_q == EMIT) && last_beat;
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);
  assign rd_en         = (state_q == FETCH);
  assign rd_row        = ky_q;

endmodule

// File: tb/tb_dwpw_window_router.sv
// Randomised and directed bench for the window router with a beat-list model.
module tb_dwpw_window_router;

  localparam int DW   = 32;
  localparam int POY  = 3;
  localparam int POX  = 16;
  localparam int KMAX = 3;
  localparam int SMAX = 2;
  localparam int BUFW = 34;
  localparam int KSW  = $clog2(KMAX + 1);
  localparam int PCW  = $clog2(BUFW + 1);
  localparam int KW   = $clog2(KMAX);
  localparam int CW   = $clog2(BUFW);

  typedef logic [POY-1:0][POX-1:0][DW-1:0]  dw_arr_t;
  typedef logic [POY-1:0][DW-1:0]           pw_arr_t;
  typedef logic [POY-1:0][BUFW-1:0][DW-1:0] line_t;

  typedef struct {
    bit      isPw;
    int      ky;
    int      kx;
    int      col;
    dw_arr_t dw;
    pw_arr_t pw;
    bit      last;
  } beat_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic           mode = 1'b0;
  logic           stride = 1'b0;
  logic [KSW-1:0] ksize = '0;
  logic [PCW-1:0] pw_cols = '0;
  logic           busy, done, rd_en;
  logic [KW-1:0]  rd_row;
  line_t          rd_data;

  dwpw_window_router_if #(.DW(DW), .POY(POY), .POX(POX), .KMAX(KMAX), .BUFW(BUFW)) bus ();

  dwpw_window_router #(
    .DW(DW), .POY(POY), .POX(POX), .KMAX(KMAX), .SMAX(SMAX), .BUFW(BUFW)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .mode    (mode),
    .ksize   (ksize),
    .stride  (stride),
    .pw_cols (pw_cols),
    .busy    (busy),
    .done    (done),
    .rd_en   (rd_en),
    .rd_row  (rd_row),
    .rd_data (rd_data),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always @(posedge clk) cyc++;

  // Image source: directed tests use y*256+c, random tests tag the kernel row too.
  bit            rowTag = 1'b0;
  logic [DW-1:0] salt = '0;

  function automatic logic [DW-1:0] pix(input int y, input int c, input int row);
    if (!rowTag) return DW'(y * 256 + c);
    return salt + DW'((row << 16) + (y << 8) + c);
  endfunction

  beat_t expQ[$];
  int    rdRows[$];
  int    beatsSeen, stallCycles, validCycles, blkendBeats, doneCount;
  int    expBeats;
  bit    capValid;
  dw_arr_t capDw;
  logic [DW-1:0] capPw1[8];
  int    readyMode = 0;
  int    stallLeft = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkDw(input string name, input dw_arr_t act, input dw_arr_t exp);
    bit found = 1'b0;
    int fy = 0;
    int fx = 0;
    for (int y = 0; y < POY; y++)
      for (int x = 0; x < POX; x++)
        if (!found && act[y][x] !== exp[y][x]) begin
          found = 1'b1; fy = y; fx = x;
        end
    checkOutput($sformatf("%s[%0d][%0d]", name, fy, fx), 64'(act[fy][fx]), 64'(exp[fy][fx]));
  endtask

  task automatic checkPw(input string name, input pw_arr_t act, input pw_arr_t exp);
    bit found = 1'b0;
    int fy = 0;
    for (int y = 0; y < POY; y++)
      if (!found && act[y] !== exp[y]) begin
        found = 1'b1; fy = y;
      end
    checkOutput($sformatf("%s[%0d]", name, fy), 64'(act[fy]), 64'(exp[fy]));
  endtask

  function automatic int effK(input int k);
    return (k < 1) ? 1 : ((k > KMAX) ? KMAX : k);
  endfunction

  function automatic int effPw(input int c);
    return (c > BUFW) ? BUFW : c;
  endfunction

  // Expected beat list of one block, straight from the tap/column rules.
  function automatic void buildBlock(input bit m, input int k, input int s, input int pwc);
    beat_t b;
    int    kk, n, sv;
    expQ.delete();
    kk = effK(k);
    n  = effPw(pwc);
    sv = s + 1;
    b.dw = '0;
    b.pw = '0;
    if (!m) begin
      for (int ky = 0; ky < kk; ky++)
        for (int kx = 0; kx < kk; kx++) begin
          b.isPw = 1'b0; b.ky = ky; b.kx = kx; b.col = 0;
          for (int y = 0; y < POY; y++)
            for (int x = 0; x < POX; x++)
              b.dw[y][x] = pix(y, x * sv + kx, ky);
          b.last = (ky == kk - 1) && (kx == kk - 1);
          expQ.push_back(b);
        end
    end else begin
      for (int col = 0; col < n; col++) begin
        b.isPw = 1'b1; b.ky = 0; b.kx = 0; b.col = col;
        for (int y = 0; y < POY; y++) b.pw[y] = pix(y, col, 0);
        b.last = (col == n - 1);
        expQ.push_back(b);
      end
    end
  endfunction

  // Line buffer: data valid only in the cycle after rd_en, junk otherwise.
  always begin : rdDriver
    bit en;
    int row;
    @(negedge clk);
    en  = (rd_en === 1'b1);
    row = int'(rd_row);
    @(posedge clk);
    #1;
    for (int y = 0; y < POY; y++)
      for (int c = 0; c < BUFW; c++)
        rd_data[y][c] = en ? pix(y, c, row) : DW'($urandom);
  end

  // Consumer ready: always, random, or a 4-cycle stall on the fourth beat.
  always begin : readyDriver
    @(posedge clk);
    #1;
    case (readyMode)
      0: bus.out_ready = 1'b1;
      1: bus.out_ready = ($urandom_range(0, 3) != 0);
      default: begin
        if (bus.out_valid && beatsSeen == 3 && stallLeft > 0) begin
          bus.out_ready = 1'b0;
          stallLeft--;
        end else begin
          bus.out_ready = 1'b1;
        end
      end
    endcase
  end

  // Compare process: every valid cycle against the head beat, hold check otherwise.
  beat_t   e;
  dw_arr_t prevDw;
  pw_arr_t prevPw;
  logic [KW-1:0] prevKy, prevKx;
  logic [CW-1:0] prevCol;
  bit      prevOk = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prevOk = 1'b0;
    end else begin
      if (rd_en) rdRows.push_back(int'(rd_row));
      if (done) doneCount++;
      if (bus.out_valid) begin
        validCycles++;
        if (expQ.size() == 0) begin
          checkOutput("unexpected_beat", 64'(1), 64'(0));
        end else begin
          e = expQ[0];
          if (e.isPw) begin
            checkOutput("pw_col", 64'(bus.pw_col), 64'(e.col));
            checkPw("pwpixel", bus.pwpixel_array, e.pw);
          end else begin
            checkOutput("tap_ky", 64'(bus.tap_ky), 64'(e.ky));
            checkOutput("tap_kx", 64'(bus.tap_kx), 64'(e.kx));
            checkDw("dwpixel", bus.dwpixel_array, e.dw);
          end
          checkOutput("blkend", 64'(bus.blkend), 64'(e.last));
          if (bus.out_ready) begin
            beatsSeen++;
            if (bus.blkend) blkendBeats++;
            if (!e.isPw && e.ky == 1 && e.kx == 2) begin
              capDw = bus.dwpixel_array;
              capValid = 1'b1;
            end
            if (e.isPw && e.col < 8) capPw1[e.col] = bus.pwpixel_array[1];
            void'(expQ.pop_front());
          end else begin
            stallCycles++;
          end
        end
      end else begin
        checkOutput("blkend_idle", 64'(bus.blkend), 64'(0));
        if (prevOk) begin
          checkDw("hold_dw", bus.dwpixel_array, prevDw);
          checkPw("hold_pw", bus.pwpixel_array, prevPw);
          checkOutput("hold_taps", 64'({bus.tap_ky, bus.tap_kx, bus.pw_col}),
                      64'({prevKy, prevKx, prevCol}));
        end
      end
      prevDw  = bus.dwpixel_array;
      prevPw  = bus.pwpixel_array;
      prevKy  = bus.tap_ky;
      prevKx  = bus.tap_kx;
      prevCol = bus.pw_col;
      prevOk  = 1'b1;
    end
  end

  // Runs one block and checks its framing against the model.
  task automatic applyStimulus(input bit m, input int k, input bit s, input int pwc,
                               input int rmode, input bit pokeStart, output int doneCyc);
    int c0, base, kk, n;
    @(posedge clk);
    #1;
    readyMode = rmode;
    stallLeft = 4;
    salt = rowTag ? DW'($urandom) : '0;
    buildBlock(m, k, int'(s), pwc);
    expBeats = expQ.size();
    beatsSeen = 0; stallCycles = 0; validCycles = 0; blkendBeats = 0; doneCount = 0;
    rdRows.delete();
    capValid = 1'b0;
    mode = m; ksize = KSW'(k); stride = s; pw_cols = PCW'(pwc);
    start = 1'b1;
    c0 = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
    mode = 1'($urandom); ksize = KSW'($urandom); stride = 1'($urandom); pw_cols = PCW'($urandom);
    doneCyc = -1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (pokeStart && cyc - c0 == 5) start = 1'b1;
      if (pokeStart && cyc - c0 == 6) start = 1'b0;
      if (done) begin
        doneCyc = cyc - c0;
        break;
      end
    end
    if (doneCyc < 0) checkOutput("done_timeout", 64'(0), 64'(1));
    @(negedge clk);
    checkOutput("done_pulse_len", 64'(done), 64'(0));
    checkOutput("busy_after_done", 64'(busy), 64'(0));
    kk = effK(k);
    n  = effPw(pwc);
    base = !m ? kk * (kk + 2) + 1 : ((n == 0) ? 1 : 3 + n);
    checkOutput("done_cycle", 64'(doneCyc), 64'(base + stallCycles));
    checkOutput("beats_left", 64'(expQ.size()), 64'(0));
    checkOutput("beat_count", 64'(beatsSeen), 64'(expBeats));
    checkOutput("done_count", 64'(doneCount), 64'(1));
    checkOutput("blkend_beats", 64'(blkendBeats), 64'(expBeats > 0 ? 1 : 0));
    n = !m ? kk : ((n == 0) ? 0 : 1);
    checkOutput("rd_row_count", 64'(rdRows.size()), 64'(n));
    for (int i = 0; i < n && i < rdRows.size(); i++)
      checkOutput($sformatf("rd_row_seq%0d", i), 64'(rdRows[i]), 64'(i));
  endtask

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int dc;
    int hit;

    rowTag = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_busy", 64'(busy), 64'(0));
    checkOutput("reset_done", 64'(done), 64'(0));
    checkOutput("reset_rd_en", 64'(rd_en), 64'(0));
    checkOutput("reset_rd_row", 64'(rd_row), 64'(0));
    checkOutput("reset_valid", 64'(bus.out_valid), 64'(0));
    checkOutput("reset_blkend", 64'(bus.blkend), 64'(0));
    checkDw("reset_dwpixel", bus.dwpixel_array, '0);
    checkPw("reset_pwpixel", bus.pwpixel_array, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("[TB] DW K=3 S=1");
    applyStimulus(1'b0, 3, 1'b0, 0, 0, 1'b0, dc);
    checkOutput("dw_s1_done16", 64'(dc), 64'(16));
    checkOutput("dw_s1_beats9", 64'(beatsSeen), 64'(9));
    checkOutput("dw_s1_blkend1", 64'(blkendBeats), 64'(1));
    checkOutput("dw_s1_cap", 64'(capValid), 64'(1));
    checkOutput("dw_s1_pix00", 64'(capDw[0][0]), 64'(32'h002));
    checkOutput("dw_s1_pix2_15", 64'(capDw[2][15]), 64'(32'h211));

    $display("[TB] DW K=3 S=2");
    applyStimulus(1'b0, 3, 1'b1, 0, 0, 1'b0, dc);
    checkOutput("dw_s2_pix0_15", 64'(capDw[0][15]), 64'(32'h020));
    checkOutput("dw_s2_pix2_15", 64'(capDw[2][15]), 64'(32'h220));

    $display("[TB] PW cols=5 and cols=0");
    applyStimulus(1'b1, 3, 1'b0, 5, 0, 1'b0, dc);
    checkOutput("pw5_done8", 64'(dc), 64'(8));
    for (int i = 0; i < 5; i++)
      checkOutput($sformatf("pw5_row1_col%0d", i), 64'(capPw1[i]), 64'(32'h100 + i));
    applyStimulus(1'b1, 3, 1'b0, 0, 0, 1'b0, dc);
    checkOutput("pw0_done1", 64'(dc), 64'(1));
    checkOutput("pw0_no_valid", 64'(validCycles), 64'(0));

    $display("[TB] backpressure on beat 4");
    applyStimulus(1'b0, 3, 1'b0, 0, 2, 1'b0, dc);
    checkOutput("bp_stalls4", 64'(stallCycles), 64'(4));
    checkOutput("bp_done20", 64'(dc), 64'(20));
    checkOutput("bp_beats9", 64'(beatsSeen), 64'(9));

    $display("[TB] clamps and start while busy");
    applyStimulus(1'b0, 0, 1'b0, 0, 0, 1'b0, dc);
    checkOutput("k0_done4", 64'(dc), 64'(4));
    checkOutput("k0_beats1", 64'(beatsSeen), 64'(1));
    applyStimulus(1'b1, 1, 1'b0, 40, 0, 1'b0, dc);
    checkOutput("pw40_beats34", 64'(beatsSeen), 64'(34));
    checkOutput("pw40_done37", 64'(dc), 64'(37));
    applyStimulus(1'b0, 3, 1'b0, 0, 0, 1'b1, dc);
    checkOutput("poke_done16", 64'(dc), 64'(16));

    $display("[TB] reset during kernel row 1");
    @(posedge clk);
    #1;
    readyMode = 0;
    buildBlock(1'b0, 3, 0, 0);
    mode = 1'b0; ksize = KSW'(3); stride = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    hit = 0;
    for (int i = 0; i < 50 && hit == 0; i++) begin
      @(negedge clk);
      if (rd_en && rd_row == KW'(1)) hit = 1;
    end
    checkOutput("reset_reach_ky1", 64'(hit), 64'(1));
    rst_n = 1'b0;
    @(negedge clk);
    expQ.delete();
    checkOutput("midrst_busy", 64'(busy), 64'(0));
    checkOutput("midrst_valid", 64'(bus.out_valid), 64'(0));
    checkOutput("midrst_done", 64'(done), 64'(0));
    checkOutput("midrst_rd_en", 64'(rd_en), 64'(0));
    checkOutput("midrst_tap_kx", 64'(bus.tap_kx), 64'(0));
    checkDw("midrst_dwpixel", bus.dwpixel_array, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    doneCount = 0;
    repeat (20) @(negedge clk);
    checkOutput("midrst_no_done", 64'(doneCount), 64'(0));
    checkOutput("midrst_idle_busy", 64'(busy), 64'(0));

    $display("[TB] randomised blocks");
    rowTag = 1'b1;
    for (int t = 0; t < 40; t++) begin
      applyStimulus(1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 40), 1, 1'b0, dc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
